// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared widths, line/address types and grant encoding for the SRAM bank arbiter.
package sram_arb_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FETCH_WIDTH = 4;
  localparam int ADDR_WIDTH = 8;
  localparam int RESP_DEPTH = 2;
  localparam int LINE_WIDTH = DATA_WIDTH * FETCH_WIDTH;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef word_t [FETCH_WIDTH-1:0] line_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} grant_e;
endpackage

// File: rtl/sram_resp_fifo.sv
// sram_resp_fifo: 2-entry read response line buffer with push, pop, synchronous flush and count.
module sram_resp_fifo
  import sram_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [LINE_WIDTH-1:0] i_data,
  output logic [LINE_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);
  logic [LINE_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr, r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_push, w_pop;
  assign w_pop = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (i_flush) begin
      r_count <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk)
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  assign o_data = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n || i_flush)
    !(i_push && r_count == 2'd2 && !w_pop));
endmodule

// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: round-robin write/read arbitration onto one single-port SRAM bank,
// with read data captured into a 2-entry back-pressured response buffer.
module sram_bank_arbiter
  import sram_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LINE_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready,
  output logic [LINE_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr_in_bank,
  output logic                  mem_cen_in_bank,
  output logic                  mem_wen_in_bank,
  output logic [LINE_WIDTH-1:0] mem_data_in_bank,
  input  logic [LINE_WIDTH-1:0] mem_data_out_bank
);
  grant_e     w_gnt;
  logic       r_rr_last, r_rd_inflight;
  logic [1:0] w_count;
  logic       w_gate, w_pop, w_wr_elig, w_rd_elig;
  assign rd_data_valid = w_count != 2'd0;
  assign w_pop = rd_data_valid & rd_data_ready;
  // rst_n in the gate keeps every grant-derived output low during an asynchronous reset.
  assign w_gate = rst_n & clk_en & ~flush;
  assign w_wr_elig = w_gate & wr_valid;
  assign w_rd_elig = w_gate & rd_valid &
    (({1'b0, w_count} + {2'b0, r_rd_inflight}) < (3'd2 + {2'b0, w_pop}));
  always_comb
    w_gnt = (w_wr_elig && (!w_rd_elig || r_rr_last)) ? GNT_WR : w_rd_elig ? GNT_RD : GNT_NONE;
  assign wr_ready = w_gnt == GNT_WR;
  assign rd_ready = w_gnt == GNT_RD;
  assign mem_cen_in_bank = w_gnt != GNT_NONE;
  assign mem_wen_in_bank = wr_ready;
  assign mem_addr_in_bank = wr_ready ? wr_addr : rd_ready ? rd_addr : '0;
  assign mem_data_in_bank = wr_ready ? wr_data : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= 1'b1;
      r_rd_inflight <= 1'b0;
    end else if (flush) begin
      r_rr_last <= 1'b1;
      r_rd_inflight <= 1'b0;
    end else begin
      if (w_gnt != GNT_NONE) r_rr_last <= rd_ready;
      r_rd_inflight <= rd_ready;
    end
  end
  // The capture push ignores clk_en so an outstanding bank read is never lost.
  sram_resp_fifo u_resp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (r_rd_inflight),
    .i_pop   (w_pop & clk_en),
    .i_data  (mem_data_out_bank),
    .o_data  (rd_data),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// tb_sram_bank_arbiter: randomized scoreboard bench with a behavioural SRAM bank and
// a transaction-level reference model of arbitration, occupancy and read data.
module tb_sram_bank_arbiter;
  import sram_arb_pkg::*;
  typedef struct {
    line_t d;
    int    cyc;
  } ent_t;
  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  clk_en, flush;
  logic                  wr_valid, wr_ready, rd_valid, rd_ready;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, mem_addr_in_bank;
  logic [LINE_WIDTH-1:0] wr_data, rd_data, mem_data_in_bank, mem_data_out_bank;
  logic                  rd_data_valid, rd_data_ready;
  logic                  mem_cen_in_bank, mem_wen_in_bank;
  line_t                 sram [256];
  line_t                 ref_mem [256];
  ent_t                  sb_q [$];
  int                    cyc, checks, errors;
  logic                  ref_last;
  always #5 clk = ~clk;
  sram_bank_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .clk_en            (clk_en),
    .flush             (flush),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .rd_addr           (rd_addr),
    .rd_data_valid     (rd_data_valid),
    .rd_data_ready     (rd_data_ready),
    .rd_data           (rd_data),
    .mem_addr_in_bank  (mem_addr_in_bank),
    .mem_cen_in_bank   (mem_cen_in_bank),
    .mem_wen_in_bank   (mem_wen_in_bank),
    .mem_data_in_bank  (mem_data_in_bank),
    .mem_data_out_bank (mem_data_out_bank)
  );
  // Behavioural single-port bank with 1-cycle read latency.
  always @(posedge clk)
    if (mem_cen_in_bank) begin
      if (mem_wen_in_bank) sram[mem_addr_in_bank] <= mem_data_in_bank;
      else mem_data_out_bank <= sram[mem_addr_in_bank];
    end
  task automatic chk(input string n, input logic [LINE_WIDTH-1:0] act, input logic [LINE_WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", n, cyc, act, exp);
    end
  endtask
  // One cycle: drive at the falling edge, check at +1, model the coming rising edge at +3.
  task automatic step(input logic wv, input logic [ADDR_WIDTH-1:0] wa, input line_t wd,
                      input logic rv, input logic [ADDR_WIDTH-1:0] ra, input logic rdr,
                      input logic ce, input logic fl);
    logic ev, g, we, re, gw, gr;
    @(negedge clk);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; rd_data_ready = rdr;
    clk_en = ce; flush = fl;
    #1;
    ev = sb_q.size() > 0 && sb_q[0].cyc + 2 <= cyc;
    g = ce & ~fl;
    we = g & wv;
    re = g & rv & ((int'(sb_q.size()) - int'(ev & rdr)) < 2);
    gw = we & (~re | ref_last);
    gr = re & ~gw;
    chk("wr_ready", wr_ready, gw);
    chk("rd_ready", rd_ready, gr);
    chk("rd_data_valid", rd_data_valid, ev);
    chk("mem_cen", mem_cen_in_bank, gw | gr);
    chk("mem_wen", mem_wen_in_bank, gw);
    chk("mem_addr", mem_addr_in_bank, gw ? wa : gr ? ra : '0);
    chk("mem_data_in", mem_data_in_bank, gw ? wd : '0);
    #2;
    if (fl) begin
      sb_q.delete();
      ref_last = 1'b1;
    end else begin
      if (gw) ref_mem[wa] = wd;
      if (gr) sb_q.push_back('{d: ref_mem[ra], cyc: cyc});
      if (gw | gr) ref_last = gr;
    end
    cyc++;
  endtask
  // Monitor: whenever the DUT presents data, compare the head and retire it on a pop.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rd_data_valid) begin
        if (sb_q.size() == 0) chk("rd_data_unexpected", rd_data_valid, 1'b0);
        else begin
          chk("rd_data", rd_data, sb_q[0].d);
          if (rd_data_ready && clk_en) void'(sb_q.pop_front());
        end
      end
    end
  end
  initial begin
    line_t l5, z;
    z = '0;
    l5 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    checks = 0; errors = 0; cyc = 0; ref_last = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    mem_data_out_bank = '0;
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0;
    wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 8'h12; rd_addr = 8'h34;
    wr_data = {4{16'hbeef}}; rd_data_ready = 1'b1;
    #13;
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_rd_data_valid", rd_data_valid, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_mem_cen", mem_cen_in_bank, 1'b0);
    chk("rst_mem_wen", mem_wen_in_bank, 1'b0);
    chk("rst_mem_addr", mem_addr_in_bank, '0);
    chk("rst_mem_data_in", mem_data_in_bank, '0);
    wr_valid = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Write 0x05 then read it back.
    step(1, 8'h05, l5, 0, 0, 1, 1, 0);
    step(0, 0, z, 1, 8'h05, 1, 1, 0);
    repeat (3) step(0, 0, z, 0, 0, 1, 1, 0);
    // Both requesters always valid: strict alternation.
    for (int i = 0; i < 8; i++) step(1, 8'(i), {2{$urandom}}, 1, 8'(i), 1, 1, 0);
    repeat (3) step(0, 0, z, 0, 0, 1, 1, 0);
    // Back-pressure: reads stop at two outstanding until a pop.
    repeat (5) step(0, 0, z, 1, 8'h05, 0, 1, 0);
    step(0, 0, z, 1, 8'h01, 1, 1, 0);
    repeat (3) step(0, 0, z, 1, 8'h02, 0, 1, 0);
    repeat (4) step(0, 0, z, 0, 0, 1, 1, 0);
    // Read then clk_en low for 3 cycles with both requesters asking.
    step(0, 0, z, 1, 8'h05, 1, 1, 0);
    repeat (3) step(1, 8'h09, {2{$urandom}}, 1, 8'h05, 1, 0, 0);
    repeat (3) step(0, 0, z, 0, 0, 1, 1, 0);
    // Read then flush: the in-flight data is discarded, next tie goes to write.
    step(0, 0, z, 1, 8'h05, 1, 1, 0);
    step(0, 0, z, 0, 0, 1, 1, 1);
    step(1, 8'h06, {2{$urandom}}, 1, 8'h06, 1, 1, 0);
    repeat (3) step(0, 0, z, 0, 0, 1, 1, 0);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 1), 8'($urandom_range(0, 7)), {$urandom, $urandom},
           $urandom_range(0, 1), 8'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);
    repeat (4) step(0, 0, z, 0, 0, 1, 1, 0);
    // Asynchronous reset with one response buffered.
    step(0, 0, z, 1, 8'h05, 0, 1, 0);
    repeat (2) step(1, 8'h07, {2{$urandom}}, 0, 0, 0, 1, 0);
    @(negedge clk);
    wr_valid = 1'b1; rd_valid = 1'b1; rd_data_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rd_data_valid", rd_data_valid, 1'b0);
    chk("arst_rd_data", rd_data, '0);
    chk("arst_wr_ready", wr_ready, 1'b0);
    chk("arst_rd_ready", rd_ready, 1'b0);
    chk("arst_mem_cen", mem_cen_in_bank, 1'b0);
    chk("arst_mem_wen", mem_wen_in_bank, 1'b0);
    chk("arst_mem_addr", mem_addr_in_bank, '0);
    chk("arst_mem_data_in", mem_data_in_bank, '0);
    sb_q.delete();
    ref_last = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h03, {2{$urandom}}, 1, 8'h03, 1, 1, 0);
    step(1, 8'h04, {2{$urandom}}, 1, 8'h03, 1, 1, 0);
    repeat (4) step(0, 0, z, 0, 0, 1, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_bank_arbiter.md
Name: sram_bank_arbiter

Overview:
- Shares one single-port SRAM bank (tsmc_name_generator wrapper: 256 x 4 x 16-bit words, 1-cycle read latency) between a write requester and a read requester.
- Round-robin arbitration on valid/ready handshakes.
- Drives the bank's addr/cen/wen/data_in pins.
- Captures read data into a 2-entry response buffer with back-pressure, so reads never overflow.

Parameters:
- DATA_WIDTH, 16, bits per word
- FETCH_WIDTH, 4, words per SRAM line
- ADDR_WIDTH, 8, SRAM line address width
- RESP_DEPTH, 2, read response buffer entries (fixed at 2; other values unsupported)

Ports:
- clk  in  1  clock; SRAM macro is on the same ungated clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  when low, no new grants; state holds except in-flight read capture
- flush  in  1  synchronous clear, not gated by clk_en
- wr_valid  in  1  write request
- wr_ready  out  1  write granted this cycle
- wr_addr  in  ADDR_WIDTH  write line address
- wr_data  in  FETCH_WIDTH x DATA_WIDTH  write line
- rd_valid  in  1  read request
- rd_ready  out  1  read granted this cycle
- rd_addr  in  ADDR_WIDTH  read line address
- rd_data_valid  out  1  response buffer non-empty
- rd_data_ready  in  1  consumer pops response
- rd_data  out  FETCH_WIDTH x DATA_WIDTH  head of response buffer
- mem_addr_in_bank  out  ADDR_WIDTH  to bank
- mem_cen_in_bank  out  1  active-high enable to bank
- mem_wen_in_bank  out  1  active-high write enable to bank
- mem_data_in_bank  out  FETCH_WIDTH x DATA_WIDTH  to bank
- mem_data_out_bank  in  FETCH_WIDTH x DATA_WIDTH  from bank, valid the cycle after a read grant

Behaviour:
- State:
  - rr_last: 0 = write, 1 = read.
  - rd_inflight flag.
  - resp_count: 0..2.
  - 2-entry buffer with wr_ptr and rd_ptr.
- Reset (rst_n low, async): rr_last=1 (write wins first tie), rd_inflight=0, resp_count=0, pointers=0.
- Output values while reset is asserted:
  - rd_data_valid=0, rd_data=0.
  - wr_ready=rd_ready=0.
  - mem_cen_in_bank=0, mem_wen_in_bank=0, mem_addr_in_bank=0, mem_data_in_bank=0.
- Eligibility:
  - gate = clk_en & ~flush.
  - rd_elig = gate & rd_valid & (resp_count + rd_inflight - pop < 2), where pop = rd_data_valid & rd_data_ready.
  - wr_elig = gate & wr_valid.
- Grant (combinational, same cycle):
  - Only one eligible: that requester is granted.
  - Both eligible: grant the one not equal to rr_last.
  - rr_last updates to the granted side on any grant.
- Readies: wr_ready = write granted, rd_ready = read granted. Each ready may depend on the other requester's valid.
- Bank pins:
  - On a grant: mem_cen_in_bank=1; mem_wen_in_bank=1 for a write; addr from the granted requester.
  - mem_data_in_bank = wr_data on a write grant, else 0.
  - No grant: all bank outputs 0.
- Read timing:
  - Read granted in cycle t sets rd_inflight for cycle t+1.
  - In t+1, mem_data_out_bank is pushed into the buffer (regardless of clk_en).
  - rd_data_valid=1 from cycle t+2; read-to-data latency is 2.
- Write timing: complete at the grant edge, no response.
- Buffer:
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pop when empty is ignored.
  - Overflow is impossible by construction. An assertion flags push while resp_count==2 and no pop.
- Ordering: read and write to the same address in one cycle are serialized by grant order. A read granted after a write sees the new data.
- clk_en low: no grants; rr_last and the buffer pop are frozen; rd_data is held. An in-flight push still completes.
- flush high:
  - No grants that cycle.
  - Next cycle: resp_count=0, pointers=0, rd_inflight=0 (data in flight is discarded), rr_last=1.
- Reset mid-operation: immediate return to reset values; an in-flight read is dropped.

Decomposition:
- Package sram_arb_pkg: DATA_WIDTH, FETCH_WIDTH, ADDR_WIDTH constants; typedefs word_t, line_t (FETCH_WIDTH x word_t), addr_t; enum grant_e {GNT_NONE, GNT_WR, GNT_RD}.
- Sub-module sram_resp_fifo: 2-entry line buffer with push, pop, flush, count, async active-low reset. The arbiter instantiates one.

Test Plan:
- Write addr 0x05 data {0x1111,0x2222,0x3333,0x4444}, then read 0x05 -> wr_ready in cycle 0; rd_ready in cycle 1; rd_data_valid in cycle 3 with the same four words.
- Both valid every cycle, rd_data_ready=1 -> grants alternate W,R,W,R starting with W; each mem_wen_in_bank matches its grant.
- rd_valid held high, rd_data_ready=0 -> exactly 2 reads granted, then rd_ready=0; resp_count=2 until a pop; after one pop, one more read is granted.
- Read granted, then clk_en=0 for 3 cycles -> data still captured; rd_data_valid=1; no new grants; mem_cen_in_bank=0 throughout.
- Read granted in cycle t, flush in t+1 -> rd_data_valid stays 0; next tie grants write.
- Assert rst_n low mid-burst with resp_count=1 -> rd_data_valid=0 and all bank outputs 0 immediately, without waiting for a clock edge.
